// File: rtl/uart_pkt_rx_if.sv
// uart_pkt_rx_if
// Byte stream in from uart_rx and assembled packet out to the command decoder.
//   in_data   [7:0]   received byte
//   in_valid          byte strobe, one cycle per byte
//   pkt_valid         one-cycle pulse, pkt_* hold a good packet
//   pkt_cmd   [7:0]   command byte
//   pkt_addr  [15:0]  {ADDR_H, ADDR_L}
//   pkt_data  [31:0]  {D3, D2, D1, D0}
// master: byte source / packet sink.  slave: the deframer.
interface uart_pkt_rx_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        pkt_valid;
    logic [7:0]  pkt_cmd;
    logic [15:0] pkt_addr;
    logic [31:0] pkt_data;

    modport master (
        output in_data, in_valid,
        input  pkt_valid, pkt_cmd, pkt_addr, pkt_data
    );

    modport slave (
        input  in_data, in_valid,
        output pkt_valid, pkt_cmd, pkt_addr, pkt_data
    );
endinterface

// File: rtl/uart_pkt_rx.sv
// uart_pkt_rx
// Deframes [CMD][ADDR_L][ADDR_H][D0][D1][D2][D3] (+ optional CRC-8 byte) from a
// byte stream. One registered pulse per packet end: pkt_valid, crc_err or
// illegal_cmd. A partial packet idle for TIMEOUT_CYC cycles is dropped with
// timeout_err.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   bus           uart_pkt_rx_if.slave (in_data/in_valid in, pkt_* out)
//   crc_en        per-packet CRC enable, sampled with the CMD byte
//   crc_err       pulse: packet dropped, CRC mismatch
//   illegal_cmd   pulse: packet dropped, cmd[7:4] > MAX_CMD
//   timeout_err   pulse: partial packet dropped on inter-byte timeout
//   busy          partial packet in progress
// Build option: PKT_RX_CRC_EN builds the CRC-8 (poly 0x07) accumulator and the
// 8-byte framing; without it crc_en is ignored and crc_err is tied low.
module uart_pkt_rx #(
    parameter int TIMEOUT_CYC = 65536,
    parameter int TO_W        = 17,
    parameter int MAX_CMD     = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    uart_pkt_rx_if.slave bus,
    input  logic         crc_en,
    output logic         crc_err,
    output logic         illegal_cmd,
    output logic         timeout_err,
    output logic         busy
);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]      MAX_TYPE = 4'(MAX_CMD);

    logic [2:0]      idx_q, idx_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]      sh_cmd_q, sh_cmd_d;
    logic [15:0]     sh_addr_q, sh_addr_d;
    logic [31:0]     sh_data_q, sh_data_d;
    logic            pkt_valid_q, pkt_valid_d;
    logic [7:0]      pkt_cmd_q, pkt_cmd_d;
    logic [15:0]     pkt_addr_q, pkt_addr_d;
    logic [31:0]     pkt_data_q, pkt_data_d;
    logic            illegal_q, illegal_d;
    logic            timeout_q, timeout_d;
    logic [2:0]      last_idx;

`ifdef PKT_RX_CRC_EN
    logic            crc_mode_q, crc_mode_d;
    logic [7:0]      crc_acc_q, crc_acc_d;
    logic            crc_err_q, crc_err_d;
    logic            crc_mode_cur;
    logic            crc_bad;

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] b);
        logic [7:0] c;
        c = crc ^ b;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction
`else
    logic unused_crc_en;
    assign unused_crc_en = crc_en;
`endif

    always_comb begin
        idx_d       = idx_q;
        to_cnt_d    = to_cnt_q;
        sh_cmd_d    = sh_cmd_q;
        sh_addr_d   = sh_addr_q;
        sh_data_d   = sh_data_q;
        pkt_valid_d = 1'b0;
        pkt_cmd_d   = pkt_cmd_q;
        pkt_addr_d  = pkt_addr_q;
        pkt_data_d  = pkt_data_q;
        illegal_d   = 1'b0;
        timeout_d   = 1'b0;
`ifdef PKT_RX_CRC_EN
        crc_mode_d   = crc_mode_q;
        crc_acc_d    = crc_acc_q;
        crc_err_d    = 1'b0;
        // At idx 0 the packet's mode is whatever crc_en says right now.
        crc_mode_cur = (idx_q == 3'd0) ? crc_en : crc_mode_q;
        last_idx     = crc_mode_cur ? 3'd7 : 3'd6;
        crc_bad      = 1'b0;
`else
        last_idx     = 3'd6;
`endif

        if (bus.in_valid) begin
            to_cnt_d = '0;
            case (idx_q)
                3'd0:    sh_cmd_d          = bus.in_data;
                3'd1:    sh_addr_d[7:0]    = bus.in_data;
                3'd2:    sh_addr_d[15:8]   = bus.in_data;
                3'd3:    sh_data_d[7:0]    = bus.in_data;
                3'd4:    sh_data_d[15:8]   = bus.in_data;
                3'd5:    sh_data_d[23:16]  = bus.in_data;
                3'd6:    sh_data_d[31:24]  = bus.in_data;
                default: ;
            endcase
`ifdef PKT_RX_CRC_EN
            if (idx_q == 3'd0) crc_mode_d = crc_en;
            if (idx_q != 3'd7) crc_acc_d = crc8_byte(crc_acc_q, bus.in_data);
            crc_bad = crc_mode_cur && (idx_q == 3'd7) && (bus.in_data != crc_acc_q);
`endif
            if (idx_q == last_idx) begin
                idx_d = '0;
`ifdef PKT_RX_CRC_EN
                crc_acc_d = '0;
                if (crc_bad) begin
                    crc_err_d = 1'b1;
                end else
`endif
                if (sh_cmd_d[7:4] > MAX_TYPE) begin
                    illegal_d = 1'b1;
                end else begin
                    pkt_valid_d = 1'b1;
                    pkt_cmd_d   = sh_cmd_d;
                    pkt_addr_d  = sh_addr_d;
                    pkt_data_d  = sh_data_d;
                end
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end else if (idx_q != 3'd0) begin
            if (to_cnt_q == TO_LAST) begin
                idx_d     = '0;
                to_cnt_d  = '0;
                timeout_d = 1'b1;
`ifdef PKT_RX_CRC_EN
                crc_acc_d = '0;
`endif
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q       <= '0;
            to_cnt_q    <= '0;
            sh_cmd_q    <= '0;
            sh_addr_q   <= '0;
            sh_data_q   <= '0;
            pkt_valid_q <= 1'b0;
            pkt_cmd_q   <= '0;
            pkt_addr_q  <= '0;
            pkt_data_q  <= '0;
            illegal_q   <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef PKT_RX_CRC_EN
            crc_mode_q  <= 1'b0;
            crc_acc_q   <= '0;
            crc_err_q   <= 1'b0;
`endif
        end else begin
            idx_q       <= idx_d;
            to_cnt_q    <= to_cnt_d;
            sh_cmd_q    <= sh_cmd_d;
            sh_addr_q   <= sh_addr_d;
            sh_data_q   <= sh_data_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_cmd_q   <= pkt_cmd_d;
            pkt_addr_q  <= pkt_addr_d;
            pkt_data_q  <= pkt_data_d;
            illegal_q   <= illegal_d;
            timeout_q   <= timeout_d;
`ifdef PKT_RX_CRC_EN
            crc_mode_q  <= crc_mode_d;
            crc_acc_q   <= crc_acc_d;
            crc_err_q   <= crc_err_d;
`endif
        end
    end

    assign bus.pkt_valid = pkt_valid_q;
    assign bus.pkt_cmd   = pkt_cmd_q;
    assign bus.pkt_addr  = pkt_addr_q;
    assign bus.pkt_data  = pkt_data_q;
    assign illegal_cmd   = illegal_q;
    assign timeout_err   = timeout_q;
    assign busy          = (idx_q != 3'd0);
`ifdef PKT_RX_CRC_EN
    assign crc_err       = crc_err_q;
`else
    assign crc_err       = 1'b0;
`endif
endmodule

// File: tb/tb_uart_pkt_rx.sv
module tb_uart_pkt_rx;
    localparam int TO = 16;
`ifdef PKT_RX_CRC_EN
    localparam bit CRC_BUILD = 1'b1;
`else
    localparam bit CRC_BUILD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic crc_en = 1'b0;
    logic crc_err, illegal_cmd, timeout_err, busy;

    uart_pkt_rx_if bus();

    uart_pkt_rx #(.TIMEOUT_CYC(TO), .TO_W(5), .MAX_CMD(7)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .crc_en(crc_en),
        .crc_err(crc_err), .illegal_cmd(illegal_cmd),
        .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pv_cyc[$];

    // reference model: bytes of the current packet, idle cycles since last byte
    bit [7:0]  mq[$];
    bit        m_mode;
    int        m_idle;
    bit        e_pv, e_crc, e_ill, e_to;
    bit [7:0]  e_cmd;
    bit [15:0] e_addr;
    bit [31:0] e_data;

    // CRC-8 as the remainder of M(x)*x^8 divided by x^8+x^2+x+1
    function automatic bit [7:0] ref_crc(input bit [55:0] msg);
        bit [63:0] m;
        m = {msg, 8'h00};
        for (int i = 63; i >= 8; i--)
            if (m[i]) m[i -: 9] = m[i -: 9] ^ 9'h107;
        return m[7:0];
    endfunction

    function automatic bit [55:0] q_msg();
        bit [55:0] r = '0;
        for (int i = 0; i < 7; i++) r = {r[47:0], mq[i]};
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_idle = 0; m_mode = 1'b0;
        e_pv = 0; e_crc = 0; e_ill = 0; e_to = 0;
        e_cmd = '0; e_addr = '0; e_data = '0;
    endtask

    task automatic model_step(input bit v, input bit [7:0] d, input bit ce);
        e_pv = 0; e_crc = 0; e_ill = 0; e_to = 0;
        if (v) begin
            if (mq.size() == 0) m_mode = CRC_BUILD && ce;
            mq.push_back(d);
            m_idle = 0;
            if (mq.size() == (m_mode ? 8 : 7)) begin
                if (m_mode && ref_crc(q_msg()) != mq[7]) e_crc = 1;
                else if (mq[0][7:4] > 4'd7)             e_ill = 1;
                else begin
                    e_pv   = 1;
                    e_cmd  = mq[0];
                    e_addr = {mq[2], mq[1]};
                    e_data = {mq[6], mq[5], mq[4], mq[3]};
                end
                mq.delete();
            end
        end else if (mq.size() != 0) begin
            m_idle++;
            if (m_idle == TO) begin
                e_to = 1;
                mq.delete();
                m_idle = 0;
            end
        end
    endtask

    task automatic cycle(input bit v, input bit [7:0] d);
        bus.in_valid = v;
        bus.in_data  = d;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step(v, d, crc_en);
        cyc++;
        #1;
        chk("pkt_valid",   bus.pkt_valid, e_pv);
        chk("crc_err",     crc_err,       e_crc);
        chk("illegal_cmd", illegal_cmd,   e_ill);
        chk("timeout_err", timeout_err,   e_to);
        chk("busy",        busy,          mq.size() != 0);
        chk("pkt_cmd",     bus.pkt_cmd,   e_cmd);
        chk("pkt_addr",    bus.pkt_addr,  e_addr);
        chk("pkt_data",    bus.pkt_data,  e_data);
        chk("pulse_excl",  32'(bus.pkt_valid) + 32'(crc_err) + 32'(illegal_cmd) + 32'(timeout_err) <= 1, 1);
        if (bus.pkt_valid) pv_cyc.push_back(cyc);
    endtask

    task automatic send7(input bit [55:0] msg);
        for (int i = 6; i >= 0; i--) cycle(1'b1, msg[i*8 +: 8]);
    endtask

    typedef struct {
        bit        v;
        bit [7:0]  d;
        bit        pv;
        bit        ill;
        bit        bsy;
        bit [31:0] data;
    } vec_t;

    vec_t tbl[16];

    initial begin
        bit [55:0] msg;
        bit [7:0]  c;
        int        n_to;
        bit [7:0]  good_b[7];
        bit [7:0]  ill_b[7];

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        model_reset();

        good_b = '{8'h01, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        ill_b  = '{8'h80, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        for (int i = 0; i < 7; i++) begin
            tbl[i]     = '{1'b1, good_b[i], i == 6, 1'b0, i != 6, (i == 6) ? 32'hDEADBEEF : 32'h0};
            tbl[8 + i] = '{1'b1, ill_b[i], 1'b0, i == 6, i != 6, 32'hDEADBEEF};
        end
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF};
        tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF};

        // reset
        cycle(0, 0); cycle(0, 0);
        chk("rst_pkt_valid", bus.pkt_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", bus.pkt_data, 0);
        rst_n = 1'b1;
        cycle(0, 0);

        // directed table: good packet then illegal command
        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].v, tbl[i].d);
            chk("tbl_pv",   bus.pkt_valid, tbl[i].pv);
            chk("tbl_ill",  illegal_cmd,   tbl[i].ill);
            chk("tbl_busy", busy,          tbl[i].bsy);
            chk("tbl_data", bus.pkt_data,  tbl[i].data);
        end
        chk("tbl_cmd",  bus.pkt_cmd,  8'h01);
        chk("tbl_addr", bus.pkt_addr, 16'h1234);

        // timeout after 3 bytes
        cycle(1, 8'h01); cycle(1, 8'h02); cycle(1, 8'h03);
        n_to = 0;
        for (int i = 0; i < TO; i++) begin
            cycle(0, 0);
            if (timeout_err) n_to++;
        end
        chk("to_pulse_last_idle", timeout_err, 1);
        chk("to_busy", busy, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0);
            if (timeout_err) n_to++;
        end
        chk("to_count", n_to, 1);
        send7(56'h02_78_56_44_33_22_11);
        chk("to_next_pv", bus.pkt_valid, 1);
        chk("to_next_data", bus.pkt_data, 32'h11223344);

        // byte in the exact timeout cycle wins
        cycle(1, 8'h03); cycle(1, 8'hAA); cycle(1, 8'hBB);
        for (int i = 0; i < TO - 1; i++) cycle(0, 0);
        cycle(1, 8'h01);
        chk("edge_no_timeout", timeout_err, 0);
        chk("edge_busy", busy, 1);
        cycle(1, 8'h02); cycle(1, 8'h03); cycle(1, 8'h04);
        chk("edge_pv", bus.pkt_valid, 1);
        chk("edge_data", bus.pkt_data, 32'h04030201);

        // back-to-back packets, then reset mid third packet
        pv_cyc.delete();
        send7(56'h05_01_00_0D_0C_0B_0A);
        send7(56'h06_02_00_1D_1C_1B_1A);
        chk("b2b_count", pv_cyc.size(), 2);
        if (pv_cyc.size() == 2) chk("b2b_spacing", pv_cyc[1] - pv_cyc[0], 7);
        cycle(1, 8'h07); cycle(1, 8'h03); cycle(1, 8'h00); cycle(1, 8'h99);
        rst_n = 1'b0;
        cycle(0, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_no_err", {crc_err, illegal_cmd, timeout_err, bus.pkt_valid}, 0);
        rst_n = 1'b1;
        for (int i = 0; i < TO + 2; i++) cycle(0, 0);
        send7(56'h03_CD_AB_04_03_02_01);
        chk("restart_pv", bus.pkt_valid, 1);
        chk("restart_addr", bus.pkt_addr, 16'hABCD);

`ifdef PKT_RX_CRC_EN
        crc_en = 1'b1;
        send7(56'h0); cycle(1, 8'h00);
        chk("crc_zero_pv", bus.pkt_valid, 1);
        chk("crc_zero_data", bus.pkt_data, 0);
        send7(56'h0); cycle(1, 8'h01);
        chk("crc_zero_bad", crc_err, 1);
        chk("crc_zero_bad_pv", bus.pkt_valid, 0);
        msg = 56'h01_00_00_00_00_00_00;
        c = ref_crc(msg);
        send7(msg); cycle(1, c);
        chk("crc_01_pv", bus.pkt_valid, 1);
        send7(msg); cycle(1, c ^ 8'h5A);
        chk("crc_01_bad", crc_err, 1);
        // CRC mismatch outranks illegal command
        msg = 56'h90_00_00_00_00_00_00;
        send7(msg); cycle(1, ref_crc(msg) ^ 8'h01);
        chk("crc_prio", crc_err, 1);
        chk("crc_prio_ill", illegal_cmd, 0);
        // crc_en dropped mid-packet: still 8-byte framing
        msg = 56'h04_10_20_30_40_50_60;
        cycle(1, msg[55:48]);
        crc_en = 1'b0;
        for (int i = 5; i >= 0; i--) cycle(1, msg[i*8 +: 8]);
        chk("crc_toggle_wait", bus.pkt_valid, 0);
        cycle(1, ref_crc(msg));
        chk("crc_toggle_pv", bus.pkt_valid, 1);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit       v;
            bit [7:0] d;
            if ($urandom_range(0, 9) == 0) crc_en = 1'($urandom_range(0, 1));
            v = ($urandom_range(0, 3) != 0);
            d = 8'($urandom);
            if (mq.size() == 0 && $urandom_range(0, 1) == 1) d[7:4] = 4'($urandom_range(0, 7));
            if (m_mode && mq.size() == 7 && $urandom_range(0, 9) < 7) d = ref_crc(q_msg());
            if (i % 300 == 299) for (int k = 0; k < TO + 2; k++) cycle(0, 0);
            cycle(v, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
